// File: rtl/csi2tx_sync_sched_pkg.sv
// Shared types and helpers for the CSI-2 TX sync-channel update scheduler.
package csi2tx_sync_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    ACK   = 3'd4
  } sched_state_t;

  localparam int MIN_HOLD = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/csi2tx_rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module csi2tx_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    win,
  output logic               vld
);

  int idx;

  // Scan from the far end down so the nearest candidate is written last.
  always_comb begin
    win = '0;
    vld = |req;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) win = ID_W'(idx);
    end
  end

endmodule

// File: rtl/csi2tx_sync_update_sched.sv
// Round-robin scheduler sharing one mux-based CDC sync channel; holds
// data for HOLD_CYCLES after the enable pulse, then acks the requester.
module csi2tx_sync_update_sched
  import csi2tx_sync_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int HOLD_CYCLES = 8,
  localparam int ID_W  = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ),
  localparam int CNT_W = (clog2(HOLD_CYCLES + 1) < 1) ? 1
                         : clog2(HOLD_CYCLES + 1)
) (
  input  logic                          clk_src,
  input  logic                          rsta,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          busy,
  output logic [ID_W-1:0]               sel_id,
  output logic [DATA_WIDTH-1:0]         sync_data,
  output logic                          sync_enable
);

  generate
    if (HOLD_CYCLES < MIN_HOLD) begin : g_bad_hold
      $error("HOLD_CYCLES must be at least 1");
    end
  endgenerate

  sched_state_t state, state_n;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win;
  logic               win_vld;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    ptr_n;
  logic [NUM_REQ-1:0] ack_mask;

  csi2tx_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .win (win),
    .vld (win_vld)
  );

  assign ptr_n = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
  assign ack_mask = NUM_REQ'(1) << sel_id;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (win_vld) state_n = LOAD;
      LOAD:    state_n = PULSE;
      PULSE:   state_n = HOLD;
      HOLD:    if (cnt == CNT_W'(1)) state_n = ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_src) begin
    if (rsta) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sel_id      <= '0;
      sync_data   <= '0;
      sync_enable <= 1'b0;
      req_ack     <= '0;
      busy        <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      busy        <= (state_n != IDLE);
      sync_enable <= (state_n == PULSE);
      req_ack     <= (state_n == ACK) ? ack_mask : '0;
      if (state == IDLE && win_vld) begin
        sel_id    <= win;
        sync_data <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == PULSE) cnt <= CNT_W'(HOLD_CYCLES);
      else if (state == HOLD) cnt <= cnt - 1'b1;
      if (state == ACK) rr_ptr <= ptr_n;
    end
  end

endmodule

// File: tb/tb_csi2tx_sync_update_sched.sv
// Directed bench for csi2tx_sync_update_sched (NUM_REQ=4, HOLD_CYCLES=4).
module tb_csi2tx_sync_update_sched;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int HC = 4;

  logic          clk = 1'b0;
  logic          rsta;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ack;
  logic          busy;
  logic [1:0]    sel_id;
  logic [DW-1:0] sync_data;
  logic          sync_enable;

  int total = 0;
  int bad = 0;

  csi2tx_sync_update_sched #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk_src     (clk),
    .rsta        (rsta),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .busy        (busy),
    .sel_id      (sel_id),
    .sync_data   (sync_data),
    .sync_enable (sync_enable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    rsta = 1'b1;
    tick();
    tick();
    rsta = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    req_data = '0;
    do_reset();
    total++;
    if ({busy, sync_enable, req_ack, sel_id} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0", {busy, sync_enable, req_ack, sel_id});
    end
    total++;
    if (sync_data !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", sync_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_data[0*DW +: DW] = 32'hA5A5_0001;
    req = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 7) req = '0;
      total++;
      if (sync_enable !== (i == 2)) begin
        bad++;
        $display("FAIL single_en c%0d got=%b want=%b", i, sync_enable, i == 2);
      end
      total++;
      if (req_ack !== ((i == 7) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL single_ack c%0d got=%b", i, req_ack);
      end
      total++;
      if (busy !== (i <= 7)) begin
        bad++;
        $display("FAIL single_busy c%0d got=%b want=%b", i, busy, i <= 7);
      end
      total++;
      if (sync_data !== 32'hA5A5_0001) begin
        bad++;
        $display("FAIL single_data c%0d got=%h want=a5a50001", i, sync_data);
      end
    end
  endtask

  task automatic test_all_req();
    int n_en;
    int n_ack;
    logic [31:0] want;
    do_reset();
    for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = 32'hC0DE_0000 + k;
    req = 4'b1111;
    n_en = 0;
    n_ack = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (sync_enable) n_en++;
      total++;
      if ((req_ack != 0) !== (i % 8 == 7)) begin
        bad++;
        $display("FAIL all_ack_time c%0d got=%b", i, req_ack);
      end
      if (req_ack != 0) begin
        want = 32'hC0DE_0000 + n_ack;
        total++;
        if (req_ack !== (4'b0001 << n_ack) || sel_id !== 2'(n_ack)) begin
          bad++;
          $display("FAIL all_order c%0d got=%b/%0d want=%0d", i, req_ack, sel_id, n_ack);
        end
        total++;
        if (sync_data !== want) begin
          bad++;
          $display("FAIL all_data c%0d got=%h want=%h", i, sync_data, want);
        end
        n_ack++;
      end
    end
    req = '0;
    total++;
    if (n_en !== 4) begin
      bad++;
      $display("FAIL all_en_count got=%0d want=4", n_en);
    end
  endtask

  task automatic test_fairness();
    int order[$];
    int exp_o[4] = '{0, 2, 0, 2};
    do_reset();
    req = 4'b0001;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i == 3) req[2] = 1'b1;
      if (req_ack != 0) order.push_back(int'(sel_id));
    end
    req = '0;
    total++;
    if (order.size() !== 4) begin
      bad++;
      $display("FAIL fair_count got=%0d want=4", order.size());
    end
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      total++;
      if (order[k] !== exp_o[k]) begin
        bad++;
        $display("FAIL fair_order k%0d got=%0d want=%0d", k, order[k], exp_o[k]);
      end
    end
  endtask

  task automatic test_payload_change();
    do_reset();
    req_data[1*DW +: DW] = 32'h1111_1111;
    req = 4'b0010;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) req_data[1*DW +: DW] = 32'h2222_2222;
      if (i == 7) begin
        total++;
        if (req_ack !== 4'b0010) begin
          bad++;
          $display("FAIL chg_ack got=%b want=0010", req_ack);
        end
        req = '0;
      end
      total++;
      if (sync_data !== 32'h1111_1111) begin
        bad++;
        $display("FAIL chg_hold c%0d got=%h want=11111111", i, sync_data);
      end
    end
    req = 4'b0010;
    tick();
    req = '0;
    total++;
    if (sync_data !== 32'h2222_2222 || sel_id !== 2'd1) begin
      bad++;
      $display("FAIL chg_regrant got=%h/%0d want=22222222/1", sync_data, sel_id);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid();
    int acks;
    do_reset();
    req_data[0*DW +: DW] = 32'h0BAD_F00D;
    req = 4'b0001;
    for (int i = 1; i <= 4; i++) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre_busy got=%b want=1", busy);
    end
    req = '0;
    rsta = 1'b1;
    tick();
    rsta = 1'b0;
    total++;
    if ({busy, sync_enable, sel_id, req_ack} !== 8'h00 || sync_data !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h want=0/0",
               {busy, sync_enable, sel_id, req_ack}, sync_data);
    end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_ack != 0 || sync_enable) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL mid_no_ack got=%0d want=0", acks);
    end
    req_data[0*DW +: DW] = 32'h5EED_0000;
    req = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) begin
        total++;
        if (sync_enable !== 1'b1 || sync_data !== 32'h5EED_0000) begin
          bad++;
          $display("FAIL mid_fresh_en got=%b/%h", sync_enable, sync_data);
        end
      end
      if (i == 7) begin
        total++;
        if (req_ack !== 4'b0001) begin
          bad++;
          $display("FAIL mid_fresh_ack got=%b want=0001", req_ack);
        end
        req = '0;
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_fresh_idle got=%b want=0", busy);
    end
  endtask

  initial begin
    rsta = 1'b1;
    req = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_all_req();
    test_fairness();
    test_payload_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csi2tx_sync_update_sched.md
Name: csi2tx_sync_update_sched

Overview:
- Source-domain scheduler that shares one mux-based CDC sync channel (data bus plus enable pulse) among NUM_REQ requesters, e.g. config/register updates crossing to the byte-clock domain.
- Arbitration is round-robin. The block registers the winner's data, issues a single-cycle enable, then holds the data stable for a programmed guard interval. The sync channel has no acknowledge, so this interval is what guarantees the destination has sampled the data.
- After the guard interval the block acks the requester.
- Sits between the source-side requesters and csi2tx_mux_based_sync, whose in_data/enable ports it drives.

Parameters:
- NUM_REQ, 4: number of requesters, 1..16.
- DATA_WIDTH, 32: width of the synchronized payload.
- HOLD_CYCLES, 8: clk_src cycles the data is held after the enable pulse.
  - Must be ≥1; elaboration error otherwise.
  - The integrator sizes it to cover pulse-sync latency at the worst clock ratio.
- Derived localparams: ID_W = max(1, clog2(NUM_REQ)); CNT_W = clog2(HOLD_CYCLES+1).

Ports:
- clk_src  in  1  source clock; all logic on its rising edge.
- rsta  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester transfer request, level; held until the matching req_ack.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened payloads; slice i = req_data[i*DATA_WIDTH +: DATA_WIDTH].
- req_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy  out  1  high when state != IDLE.
- sel_id  out  ID_W  index of the current or last granted requester.
- sync_data  out  DATA_WIDTH  drives in_data of the sync channel.
- sync_enable  out  1  drives enable of the sync channel; single-cycle pulse.

Behaviour:
- Reset (rsta=1 at a clk_src edge): state=IDLE, rr_ptr=0, sel_id=0, sync_data=0, sync_enable=0, req_ack=0, busy=0, counter=0.
- All outputs are registered.
- IDLE:
  - If req != 0: winner = first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - At the edge: sel_id<=winner, sync_data<=slice(winner), state<=LOAD.
  - Otherwise remain in IDLE.
- LOAD: one cycle of data setup, sync_enable=0; go to PULSE.
- PULSE: sync_enable=1 for this cycle only; counter<=HOLD_CYCLES; go to HOLD.
- HOLD:
  - Counter decrements each cycle.
  - When counter==1, go to ACK, so HOLD lasts exactly HOLD_CYCLES cycles.
- ACK: req_ack[sel_id]=1 for this cycle only; rr_ptr<=(sel_id+1) mod NUM_REQ; go to IDLE.
- Latency: req seen in IDLE at cycle t gives:
  - sync_data valid at t+1
  - sync_enable at t+2
  - req_ack at t+3+HOLD_CYCLES
  - back in IDLE at t+4+HOLD_CYCLES.
- Back-to-back period is HOLD_CYCLES+4 cycles. Arbitration occurs only in IDLE.
- sync_data is stable from LOAD until the next grant; it is never cleared except by reset.
- Payload is captured at grant. Later changes to req_data are ignored for that transfer.
- If req drops before ack, the transfer still completes and req_ack is still pulsed.
- A requester holding req after its ack is re-arbitrated behind the others (round-robin fairness).
- NUM_REQ=1: rr_ptr stays 0, sel_id stays 0.
- Reset mid-transfer (any state): next cycle is IDLE.
  - No req_ack is issued and no further sync_enable.
  - The in-flight update is lost; requesters re-request.
- Only one bit of req_ack is ever set, and sync_enable never asserts twice within one transfer.

Decomposition:
- Shared package csi2tx_sync_sched_pkg:
  - state encoding IDLE/LOAD/PULSE/HOLD/ACK (3-bit)
  - clog2 function
  - HOLD_CYCLES minimum check constant
- Sub-module csi2tx_rr_arbiter: combinational priority search from rr_ptr, outputs winner index and a valid flag. The pointer register stays in the parent.

Test Plan (NUM_REQ=4, DATA_WIDTH=32, HOLD_CYCLES=4 unless noted):
1. Single request: req=4'b0001, slice0=32'hA5A5_0001 at cycle 0.
   - Response: sync_data=32'hA5A50001 from cycle 1; sync_enable high only at cycle 2; req_ack=4'b0001 at cycle 7; busy high cycles 1–7, low at 8.
2. req=4'b1111 held throughout, distinct payloads.
   - Response: sel_id sequence 0,1,2,3; acks at cycles 7,15,23,31; exactly one sync_enable per 8 cycles.
3. Fairness: req0 held permanently, req2 asserted at cycle 3.
   - Response: service order 0,2,0,2; req0 never served twice in a row while req2 is pending.
4. Payload change during HOLD: slice1 changed from 32'h1111_1111 to 32'h2222_2222.
   - Response: sync_data stays 32'h11111111 through ACK and until the next grant.
5. rsta pulsed during HOLD.
   - Response: next cycle busy=0, sync_enable=0, sync_data=0, sel_id=0; no req_ack; a fresh req0 is then served normally.
6. End-to-end: connected to csi2tx_mux_based_sync, clk_dest=clk_src/2, HOLD_CYCLES=8, 16 random updates.
   - Response: out_data sequence equals the granted payload sequence with no drops or duplicates.
